// File: rtl/leiwand_rv32_bus_arbiter_if.sv
// rtl/leiwand_rv32_bus_arbiter_if.sv - valid/ready/wen/addr/wdata/rdata peripheral bus bundle
interface leiwand_rv32_bus_arbiter_if #(
    parameter int XLEN = 32
);
    logic              valid;
    logic              ready;
    logic [XLEN/8-1:0] wen;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [XLEN-1:0]   rdata;

    modport master (
        output valid,
        output wen,
        output addr,
        output wdata,
        input  ready,
        input  rdata
    );

    modport slave (
        input  valid,
        input  wen,
        input  addr,
        input  wdata,
        output ready,
        output rdata
    );
endinterface

// File: rtl/leiwand_rv32_bus_arbiter.sv
// rtl/leiwand_rv32_bus_arbiter.sv - two-master round-robin peripheral arbiter, watchdog under LEIWAND_RV32_ARB_TIMEOUT_EN
module leiwand_rv32_bus_arbiter #(
    parameter int XLEN = 32
`ifdef LEIWAND_RV32_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    leiwand_rv32_bus_arbiter_if.slave  m0_if,
    leiwand_rv32_bus_arbiter_if.slave  m1_if,
    leiwand_rv32_bus_arbiter_if.master s_if
`ifdef LEIWAND_RV32_ARB_TIMEOUT_EN
    ,
    output logic                       bus_err
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            grant_q, grant_d;
    logic            last_grant_q, last_grant_d;
    logic            m0_ready_q, m0_ready_d;
    logic            m1_ready_q, m1_ready_d;
    logic [XLEN-1:0] m0_rdata_q, m0_rdata_d;
    logic [XLEN-1:0] m1_rdata_q, m1_rdata_d;

    logic            busy;
    logic            complete;
    logic [XLEN-1:0] resp_data;

    assign busy = (state_q == ST_BUSY);

`ifdef LEIWAND_RV32_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;
    logic             timeout_hit;

    // Last waiting BUSY cycle before the limit; a real s_ready in that cycle wins.
    assign timeout_hit = busy && !s_if.ready && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign complete    = busy && (s_if.ready || timeout_hit);
    assign resp_data   = s_if.ready ? s_if.rdata : XLEN'(32'hDEADBEEF);
    assign bus_err_d   = timeout_hit;
    assign bus_err     = bus_err_q;

    // Watchdog counter: held at zero outside BUSY, counts unanswered BUSY cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q != ST_BUSY) begin
            cnt_d = '0;
        end else if (!s_if.ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Watchdog state and the single-cycle error flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end
`else
    assign complete  = busy && s_if.ready;
    assign resp_data = s_if.rdata;
`endif

    // Next-state logic: grant on a request, complete on slave ready, hold off until ready drops.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        m0_ready_d   = 1'b0;
        m1_ready_d   = 1'b0;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_if.valid || m1_if.valid) begin
                    // On a tie the master that did not win last time goes first.
                    grant_d = (m0_if.valid && m1_if.valid) ? ~last_grant_q : m1_if.valid;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (complete) begin
                    if (grant_q) begin
                        m1_ready_d = 1'b1;
                        m1_rdata_d = resp_data;
                    end else begin
                        m0_ready_d = 1'b1;
                        m0_rdata_d = resp_data;
                    end
                    last_grant_d = grant_q;
                    state_d      = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!s_if.ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register and registered master responses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            m0_ready_q   <= 1'b0;
            m1_ready_q   <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            m0_ready_q   <= m0_ready_d;
            m1_ready_q   <= m1_ready_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    assign s_if.valid  = busy;
    assign s_if.wen    = busy ? (grant_q ? m1_if.wen : m0_if.wen) : '0;
    assign s_if.addr   = grant_q ? m1_if.addr : m0_if.addr;
    assign s_if.wdata  = grant_q ? m1_if.wdata : m0_if.wdata;

    assign m0_if.ready = m0_ready_q;
    assign m0_if.rdata = m0_rdata_q;
    assign m1_if.ready = m1_ready_q;
    assign m1_if.rdata = m1_rdata_q;

endmodule

// File: tb/tb_leiwand_rv32_bus_arbiter.sv
// tb/tb_leiwand_rv32_bus_arbiter.sv - self-checking bench for leiwand_rv32_bus_arbiter
module tb_leiwand_rv32_bus_arbiter;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;

    leiwand_rv32_bus_arbiter_if #(.XLEN(XLEN)) m0_bus ();
    leiwand_rv32_bus_arbiter_if #(.XLEN(XLEN)) m1_bus ();
    leiwand_rv32_bus_arbiter_if #(.XLEN(XLEN)) s_bus ();

`ifdef LEIWAND_RV32_ARB_TIMEOUT_EN
    logic bus_err;
    leiwand_rv32_bus_arbiter #(.XLEN(XLEN), .TIMEOUT_CYCLES(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .m0_if  (m0_bus),
        .m1_if  (m1_bus),
        .s_if   (s_bus),
        .bus_err(bus_err)
    );
`else
    leiwand_rv32_bus_arbiter #(.XLEN(XLEN)) dut (
        .clk  (clk),
        .rst  (rst),
        .m0_if(m0_bus),
        .m1_if(m1_bus),
        .s_if (s_bus)
    );
`endif

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        m0v, m1v, sr;
        logic [31:0] srd;
        logic        e_sv, e_own, e_r0, e_r1;
        logic [31:0] e_rd0, e_rd1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic m0v, input logic m1v, input logic sr, input logic [31:0] srd,
                                input logic e_sv, input logic e_own, input logic e_r0, input logic e_r1,
                                input logic [31:0] e_rd0, input logic [31:0] e_rd1);
        vec_t v;
        v.m0v = m0v; v.m1v = m1v; v.sr = sr; v.srd = srd;
        v.e_sv = e_sv; v.e_own = e_own; v.e_r0 = e_r0; v.e_r1 = e_r1;
        v.e_rd0 = e_rd0; v.e_rd1 = e_rd1;
        return v;
    endfunction

    task automatic idle_inputs();
        m0_bus.valid = 1'b0; m0_bus.wen = '0; m0_bus.addr = '0; m0_bus.wdata = '0;
        m1_bus.valid = 1'b0; m1_bus.wen = '0; m1_bus.addr = '0; m1_bus.wdata = '0;
        s_bus.ready  = 1'b0; s_bus.rdata = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        @(posedge clk); #1;
        check("rst_s_valid", s_bus.valid, 0);
        check("rst_s_wen", s_bus.wen, 0);
        check("rst_m0_ready", m0_bus.ready, 0);
        check("rst_m1_ready", m1_bus.ready, 0);
        check("rst_m0_rdata", m0_bus.rdata, 0);
        check("rst_m1_rdata", m1_bus.rdata, 0);
`ifdef LEIWAND_RV32_ARB_TIMEOUT_EN
        check("rst_bus_err", bus_err, 0);
`endif
        rst = 1'b1;
    endtask

    // One-cycle slave: answers the cycle after it first sees s_valid, until master m gets ready.
    task automatic serve(input int m, input logic [31:0] data, input int budget, output bit ok);
        bit sv_seen;
        sv_seen = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk); #1;
            s_bus.ready = sv_seen && !s_bus.ready;
            s_bus.rdata = data;
            @(negedge clk);
            sv_seen = s_bus.valid;
            if ((m == 0) ? m0_bus.ready : m1_bus.ready) begin
                ok = 1'b1;
                check("serve_other_ready", (m == 0) ? m1_bus.ready : m0_bus.ready, 0);
            end
        end
    endtask

    task automatic run_random(input int cycles);
        bit          pend[2], done[2], exp_r[2];
        logic [31:0] ra[2], rw[2], exp_rd[2];
        logic [3:0]  rwe[2];
        bit          exp_sv, releasing, owner, last, sl_active;
        int          sl_cnt, sl_stuck;
        logic [3:0]  ewen;
        for (int m = 0; m < 2; m++) begin
            pend[m] = 0; done[m] = 0; exp_r[m] = 0; exp_rd[m] = '0;
            ra[m] = '0; rw[m] = '0; rwe[m] = '0;
        end
        exp_sv = 0; releasing = 0; owner = 0; last = 1; sl_active = 0; sl_cnt = 0; sl_stuck = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            for (int m = 0; m < 2; m++) begin
                if (!pend[m] && !done[m] && $urandom_range(0, 2) == 0) begin
                    pend[m] = 1;
                    ra[m]   = $urandom;
                    rw[m]   = $urandom;
                    rwe[m]  = 4'($urandom_range(0, 15));
                end
                done[m] = 0;
            end
            m0_bus.valid = pend[0]; m0_bus.addr = ra[0]; m0_bus.wdata = rw[0]; m0_bus.wen = rwe[0];
            m1_bus.valid = pend[1]; m1_bus.addr = ra[1]; m1_bus.wdata = rw[1]; m1_bus.wen = rwe[1];
            if (s_bus.ready) begin
                if (sl_stuck > 0) sl_stuck--;
                else s_bus.ready = 1'b0;
            end else if (sl_active) begin
                if (sl_cnt == 0) begin
                    s_bus.ready = 1'b1;
                    s_bus.rdata = $urandom;
                    sl_active   = 0;
                    sl_stuck    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                end else begin
                    sl_cnt--;
                end
            end
            @(negedge clk);
            check("rnd_s_valid", s_bus.valid, exp_sv);
            if (s_bus.valid) begin
                check("rnd_s_addr", s_bus.addr, ra[owner]);
                check("rnd_s_wdata", s_bus.wdata, rw[owner]);
                ewen = rwe[owner];
            end else begin
                ewen = 4'h0;
            end
            check("rnd_s_wen", s_bus.wen, ewen);
            check("rnd_m0_ready", m0_bus.ready, exp_r[0]);
            check("rnd_m1_ready", m1_bus.ready, exp_r[1]);
            check("rnd_m0_rdata", m0_bus.rdata, exp_rd[0]);
            check("rnd_m1_rdata", m1_bus.rdata, exp_rd[1]);
            exp_r[0] = 0; exp_r[1] = 0;
            if (s_bus.valid) begin
                if (s_bus.ready) begin
                    exp_r[owner]  = 1;
                    exp_rd[owner] = s_bus.rdata;
                    last          = owner;
                    releasing     = 1;
                    exp_sv        = 0;
                end else begin
                    exp_sv = 1;
                end
            end else if (releasing) begin
                exp_sv = 0;
                if (!s_bus.ready) releasing = 0;
            end else if (pend[0] || pend[1]) begin
                owner  = (pend[0] && pend[1]) ? !last : pend[1];
                exp_sv = 1;
            end else begin
                exp_sv = 0;
            end
            if (s_bus.valid && !s_bus.ready && !sl_active) begin
                sl_active = 1;
                sl_cnt    = $urandom_range(0, 3);
            end
            if (m0_bus.ready) begin pend[0] = 0; done[0] = 1; end
            if (m1_bus.ready) begin pend[1] = 0; done[1] = 1; end
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit          ok, seen;
        int          busy_cnt;
        logic [31:0] ewen;
        logic [31:0] R0, R1;
        R0 = 32'hC0DE0001;
        R1 = 32'h12345678;

        // write by m0, read by m1, 4-way contention, stuck slave in release
        vecs.push_back(mk(1,0,0,0,            0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,            1,0,0,0,0,0));
        vecs.push_back(mk(1,0,1,R0,           1,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,            0,0,1,0,R0,0));
        vecs.push_back(mk(0,0,0,0,            0,0,0,0,R0,0));
        vecs.push_back(mk(0,1,0,0,            0,0,0,0,R0,0));
        vecs.push_back(mk(0,1,0,0,            1,1,0,0,R0,0));
        vecs.push_back(mk(0,1,1,R1,           1,1,0,0,R0,0));
        vecs.push_back(mk(0,1,0,0,            0,0,0,1,R0,R1));
        vecs.push_back(mk(0,0,0,0,            0,0,0,0,R0,R1));
        vecs.push_back(mk(1,1,0,0,            0,0,0,0,R0,R1));
        vecs.push_back(mk(1,1,0,0,            1,0,0,0,R0,R1));
        vecs.push_back(mk(1,1,1,32'hA0,       1,0,0,0,R0,R1));
        vecs.push_back(mk(1,1,0,0,            0,0,1,0,32'hA0,R1));
        vecs.push_back(mk(1,1,0,0,            0,0,0,0,32'hA0,R1));
        vecs.push_back(mk(1,1,0,0,            1,1,0,0,32'hA0,R1));
        vecs.push_back(mk(1,1,1,32'hA1,       1,1,0,0,32'hA0,R1));
        vecs.push_back(mk(1,1,0,0,            0,0,0,1,32'hA0,32'hA1));
        vecs.push_back(mk(1,1,0,0,            0,0,0,0,32'hA0,32'hA1));
        vecs.push_back(mk(1,1,0,0,            1,0,0,0,32'hA0,32'hA1));
        vecs.push_back(mk(1,1,1,32'hA2,       1,0,0,0,32'hA0,32'hA1));
        vecs.push_back(mk(1,1,0,0,            0,0,1,0,32'hA2,32'hA1));
        vecs.push_back(mk(1,1,0,0,            0,0,0,0,32'hA2,32'hA1));
        vecs.push_back(mk(1,1,0,0,            1,1,0,0,32'hA2,32'hA1));
        vecs.push_back(mk(1,1,1,32'hA3,       1,1,0,0,32'hA2,32'hA1));
        vecs.push_back(mk(1,1,0,0,            0,0,0,1,32'hA2,32'hA3));
        vecs.push_back(mk(0,0,0,0,            0,0,0,0,32'hA2,32'hA3));
        vecs.push_back(mk(0,0,0,0,            0,0,0,0,32'hA2,32'hA3));
        vecs.push_back(mk(1,0,0,0,            0,0,0,0,32'hA2,32'hA3));
        vecs.push_back(mk(1,0,0,0,            1,0,0,0,32'hA2,32'hA3));
        vecs.push_back(mk(1,0,1,32'h77,       1,0,0,0,32'hA2,32'hA3));
        vecs.push_back(mk(1,1,1,0,            0,0,1,0,32'h77,32'hA3));
        vecs.push_back(mk(0,1,1,0,            0,0,0,0,32'h77,32'hA3));
        vecs.push_back(mk(0,1,1,0,            0,0,0,0,32'h77,32'hA3));
        vecs.push_back(mk(0,1,1,0,            0,0,0,0,32'h77,32'hA3));
        vecs.push_back(mk(0,1,0,0,            0,0,0,0,32'h77,32'hA3));
        vecs.push_back(mk(0,1,0,0,            0,0,0,0,32'h77,32'hA3));
        vecs.push_back(mk(0,1,0,0,            1,1,0,0,32'h77,32'hA3));
        vecs.push_back(mk(0,1,1,32'h88,       1,1,0,0,32'h77,32'hA3));
        vecs.push_back(mk(0,1,0,0,            0,0,0,1,32'h77,32'h88));
        vecs.push_back(mk(0,0,0,0,            0,0,0,0,32'h77,32'h88));

        idle_inputs();
        do_reset();

        m0_bus.addr = 32'h0;   m0_bus.wdata = 32'h41; m0_bus.wen = 4'hF;
        m1_bus.addr = 32'h100; m1_bus.wdata = 32'h55; m1_bus.wen = 4'h0;
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            m0_bus.valid = vecs[i].m0v;
            m1_bus.valid = vecs[i].m1v;
            s_bus.ready  = vecs[i].sr;
            s_bus.rdata  = vecs[i].srd;
            @(negedge clk);
            check($sformatf("vec%0d_s_valid", i), s_bus.valid, vecs[i].e_sv);
            check($sformatf("vec%0d_m0_ready", i), m0_bus.ready, vecs[i].e_r0);
            check($sformatf("vec%0d_m1_ready", i), m1_bus.ready, vecs[i].e_r1);
            check($sformatf("vec%0d_m0_rdata", i), m0_bus.rdata, vecs[i].e_rd0);
            check($sformatf("vec%0d_m1_rdata", i), m1_bus.rdata, vecs[i].e_rd1);
            ewen = vecs[i].e_sv ? (vecs[i].e_own ? 32'h0 : 32'hF) : 32'h0;
            check($sformatf("vec%0d_s_wen", i), s_bus.wen, ewen);
            if (vecs[i].e_sv) begin
                check($sformatf("vec%0d_s_addr", i), s_bus.addr, vecs[i].e_own ? 32'h100 : 32'h0);
                check($sformatf("vec%0d_s_wdata", i), s_bus.wdata, vecs[i].e_own ? 32'h55 : 32'h41);
            end
        end

        // reset while BUSY, then the held request is re-granted
        @(posedge clk); #1;
        m0_bus.valid = 1'b1; m1_bus.valid = 1'b0; s_bus.ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rstmid_busy", s_bus.valid, 1);
        @(posedge clk); #1;
        rst = 1'b0; s_bus.ready = 1'b1; s_bus.rdata = 32'h99;
        @(posedge clk); #1;
        check("rstmid_s_valid", s_bus.valid, 0);
        check("rstmid_m0_ready", m0_bus.ready, 0);
        check("rstmid_m0_rdata", m0_bus.rdata, 0);
        rst = 1'b1; s_bus.ready = 1'b0;
        serve(0, 32'h5A5A0001, 20, ok);
        check("rstmid_done", ok, 1);
        check("rstmid_rdata", m0_bus.rdata, 32'h5A5A0001);

`ifdef LEIWAND_RV32_ARB_TIMEOUT_EN
        // silent slave: watchdog completes the transfer after 8 BUSY cycles
        @(posedge clk); #1;
        s_bus.ready = 1'b0;
        seen = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (m0_bus.ready) begin
                seen = 1'b1;
                check("to_bus_err", bus_err, 1);
                check("to_rdata", m0_bus.rdata, 32'hDEADBEEF);
            end else if (s_bus.valid) begin
                busy_cnt++;
            end
            @(posedge clk); #1;
        end
        check("to_seen", seen, 1);
        check("to_busy_cycles", busy_cnt, 8);
        m0_bus.valid = 1'b0;
        m1_bus.valid = 1'b1;
        serve(1, 32'h31, 20, ok);
        check("to_next_done", ok, 1);
        check("to_next_err", bus_err, 0);
        check("to_next_rdata", m1_bus.rdata, 32'h31);
        m1_bus.valid = 1'b0;
`else
        seen = 1'b0;
        busy_cnt = 0;
        if (seen) busy_cnt = 1;
`endif
        @(posedge clk); #1;
        idle_inputs();

        do_reset();
        run_random(1500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
